sim_spi_ram_sync: RTL and testbench

- Parametrised, single-clock successor to the team's SPI RAM simulation model.
- Oversamples an external SPI bus on the system clock and serves commands 03h (read), 0Bh (fast read with dummy cycles) and 02h (write) from a byte array of configurable depth.
- Adds a 32-bit debug read/preload port and a sticky error flag; addresses wrap at the array size.
- Used as the external RAM in top-level CPU benches.

---
 rtl/sim_spi_ram_sync_if.sv | 24 ++
 rtl/sim_spi_ram_sync.sv | 152 +++++++++++++++
 tb/tb_sim_spi_ram_sync.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/sim_spi_ram_sync_if.sv
// Bus bundle for the SPI RAM model: external SPI pins plus the debug word port.
interface sim_spi_ram_sync_if #(
   parameter int DEPTH_LOG2 = 16
);
   logic                  spi_clk;
   logic                  spi_mosi;
   logic                  spi_select;
   logic                  spi_miso;
   logic [DEPTH_LOG2-3:0] debug_addr;
   logic                  debug_we;
   logic [31:0]           debug_wdata;
   logic [31:0]           debug_data;
   logic                  error;

   modport master (
      output spi_clk, spi_mosi, spi_select, debug_addr, debug_we, debug_wdata,
      input  spi_miso, debug_data, error
   );

   modport slave (
      input  spi_clk, spi_mosi, spi_select, debug_addr, debug_we, debug_wdata,
      output spi_miso, debug_data, error
   );
endinterface

// File: rtl/sim_spi_ram_sync.sv
// SPI RAM model oversampled on clk: serves 03h/0Bh/02h from a wrapping byte array,
// with a little-endian 32-bit debug port and a sticky unknown-command flag.
module sim_spi_ram_sync #(
   parameter int    DEPTH_LOG2   = 16,
   parameter int    ADDR_BYTES   = 3,
   parameter int    DUMMY_CYCLES = 8,
   parameter string INIT_FILE    = ""
) (
   input logic               clk,
   input logic               rst,
   sim_spi_ram_sync_if.slave bus
);
   localparam int         DEPTH      = 1 << DEPTH_LOG2;
   localparam logic [7:0] ADDR_LAST  = 8'(8 * ADDR_BYTES - 1);
   localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_CYCLES - 1);
   localparam logic [7:0] OP_READ    = 8'h03;
   localparam logic [7:0] OP_FAST    = 8'h0B;
   localparam logic [7:0] OP_WRITE   = 8'h02;

   typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, READ, WRITE, IGNORE} state_t;

   state_t                  state_q, state_d;
   logic [2:0]              sclk_pipe, mosi_pipe, sel_pipe;
   logic                    sclk_sync, sclk_prev, mosi_sync, sel_sync;
   logic                    rise, fall;
   logic [7:0]              bit_cnt;
   logic [7:0]              shift_q, shift_in, cmd_q, rd_byte;
   logic [DEPTH_LOG2-1:0]   addr_q;
   logic                    miso_q, miso_d, error_q, cmd_known, spi_we;
   logic [31:0]             debug_data_q;
   logic [7:0]              mem [DEPTH];

   // Two meta-stages per pin; the third spi_clk stage holds the previous sample for edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sclk_pipe <= 3'b000;
         mosi_pipe <= 3'b000;
         sel_pipe  <= 3'b111;
      end else begin
         // NOTE: sequential state always uses <= so every flop samples pre-edge values.
         sclk_pipe <= {sclk_pipe[1:0], bus.spi_clk};
         mosi_pipe <= {mosi_pipe[1:0], bus.spi_mosi};
         sel_pipe  <= {sel_pipe[1:0], bus.spi_select};
      end
   end

   assign sclk_sync = sclk_pipe[1];
   assign sclk_prev = sclk_pipe[2];
   assign mosi_sync = mosi_pipe[1];
   assign sel_sync  = sel_pipe[1];
   assign rise      = sclk_sync & ~sclk_prev;
   assign fall      = ~sclk_sync & sclk_prev;
   assign shift_in  = {shift_q[6:0], mosi_sync};
   assign cmd_known = (shift_in == OP_READ) || (shift_in == OP_FAST) || (shift_in == OP_WRITE);
   assign rd_byte   = mem[addr_q];
   assign spi_we    = !sel_sync && state_q == WRITE && rise && bit_cnt == 8'd7;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      // NOTE: defaulting every always_comb output first keeps unassigned paths from inferring latches.
      state_d = state_q;
      if (sel_sync) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:  state_d = CMD;
            CMD:   if (rise && bit_cnt == 8'd7) state_d = cmd_known ? ADDR : IGNORE;
            ADDR:  if (rise && bit_cnt == ADDR_LAST) begin
                      if (cmd_q == OP_WRITE)     state_d = WRITE;
                      else if (cmd_q == OP_FAST) state_d = (DUMMY_CYCLES == 0) ? READ : DUMMY;
                      else                       state_d = READ;
                   end
            DUMMY: if (rise && bit_cnt == DUMMY_LAST) state_d = READ;
            default: ;
         endcase
      end
   end

   // miso follows the array only while in READ; bit index 7-bit_cnt is the inverted low count.
   always_comb begin
      miso_d = miso_q;
      if (sel_sync || state_q != READ) miso_d = 1'b0;
      else if (fall)                   miso_d = rd_byte[~bit_cnt[2:0]];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_cnt <= '0;
         shift_q <= '0;
         cmd_q   <= '0;
         addr_q  <= '0;
         miso_q  <= 1'b0;
         error_q <= 1'b0;
      end else begin
         miso_q <= miso_d;
         if (sel_sync || state_q == IDLE) begin
            bit_cnt <= '0;
            shift_q <= '0;
         end else begin
            case (state_q)
               CMD: if (rise) begin
                  shift_q <= shift_in;
                  bit_cnt <= (bit_cnt == 8'd7) ? 8'd0 : bit_cnt + 8'd1;
                  if (bit_cnt == 8'd7) begin
                     cmd_q  <= shift_in;
                     addr_q <= '0;
                     if (!cmd_known) error_q <= 1'b1;
                  end
               end
               ADDR: if (rise) begin
                  addr_q  <= {addr_q[DEPTH_LOG2-2:0], mosi_sync};
                  bit_cnt <= (bit_cnt == ADDR_LAST) ? 8'd0 : bit_cnt + 8'd1;
               end
               DUMMY: if (rise) bit_cnt <= (bit_cnt == DUMMY_LAST) ? 8'd0 : bit_cnt + 8'd1;
               READ: if (fall) begin
                  bit_cnt <= (bit_cnt == 8'd7) ? 8'd0 : bit_cnt + 8'd1;
                  if (bit_cnt == 8'd7) addr_q <= addr_q + 1'b1;
               end
               WRITE: if (rise) begin
                  shift_q <= shift_in;
                  bit_cnt <= (bit_cnt == 8'd7) ? 8'd0 : bit_cnt + 8'd1;
                  if (bit_cnt == 8'd7) addr_q <= addr_q + 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   // NOTE: the byte array has no reset so its contents survive rst, as a real RAM would.
   always_ff @(posedge clk) begin
      if (bus.debug_we) begin
         for (int i = 0; i < 4; i++) mem[{bus.debug_addr, 2'(i)}] <= bus.debug_wdata[8*i +: 8];
      end
      // Later assignment wins, so an SPI byte write overrides a debug write to the same byte.
      if (spi_we) mem[addr_q] <= shift_in;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) debug_data_q <= '0;
      else     debug_data_q <= {mem[{bus.debug_addr, 2'd3}], mem[{bus.debug_addr, 2'd2}],
                                mem[{bus.debug_addr, 2'd1}], mem[{bus.debug_addr, 2'd0}]};
   end

   assign bus.spi_miso   = miso_q;
   assign bus.debug_data = debug_data_q;
   assign bus.error      = error_q;
endmodule

// File: tb/tb_sim_spi_ram_sync.sv
// Scoreboard bench for sim_spi_ram_sync: directed SPI frames and debug accesses.
module tb_sim_spi_ram_sync;
   localparam int HALF = 40;

   typedef struct {
      string       name;
      logic [31:0] val;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic cap_en = 1'b0;
   logic dbg_rd_req = 1'b0;
   int   total = 0;
   int   bad = 0;
   exp_t exp_spi[$];
   exp_t exp_dbg[$];

   sim_spi_ram_sync_if #(.DEPTH_LOG2(16)) bus ();

   sim_spi_ram_sync #(
      .DEPTH_LOG2(16), .ADDR_BYTES(3), .DUMMY_CYCLES(8), .INIT_FILE("")
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // SPI monitor: master samples miso on each rising spi_clk while capture is enabled.
   initial begin
      logic [7:0] rx;
      int         n;
      exp_t       e;
      rx = '0;
      n  = 0;
      forever begin
         @(posedge bus.spi_clk);
         if (cap_en) begin
            rx = {rx[6:0], bus.spi_miso};
            n++;
            if (n == 8) begin
               n = 0;
               if (exp_spi.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL spi_unexpected_byte: got %h with no expectation queued", rx);
               end else begin
                  e = exp_spi.pop_front();
                  check(e.name, 32'(rx), e.val);
               end
            end
         end
      end
   end

   // Debug monitor: a request seen at a clock edge has its word valid by the following falling edge.
   initial begin
      logic req;
      exp_t e;
      forever begin
         @(posedge clk);
         req = dbg_rd_req;
         @(negedge clk);
         if (req) begin
            if (exp_dbg.size() == 0) begin
               total++;
               bad++;
               $display("FAIL dbg_unexpected_word: got %h with no expectation queued", bus.debug_data);
            end else begin
               e = exp_dbg.pop_front();
               check(e.name, bus.debug_data, e.val);
            end
         end
      end
   end

   task automatic dbg_write(input logic [13:0] a, input logic [31:0] d);
      @(negedge clk);
      bus.debug_addr  = a;
      bus.debug_wdata = d;
      bus.debug_we    = 1'b1;
      @(negedge clk);
      bus.debug_we    = 1'b0;
   endtask

   task automatic dbg_read(input logic [13:0] a, input logic [31:0] exp, input string name);
      @(negedge clk);
      bus.debug_addr = a;
      exp_dbg.push_back('{name, exp});
      dbg_rd_req = 1'b1;
      @(negedge clk);
      dbg_rd_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic spi_bits(input logic [7:0] tx, input int nbits);
      for (int i = 7; i > 7 - nbits; i--) begin
         bus.spi_mosi = tx[i];
         #(HALF) bus.spi_clk = 1'b1;
         #(HALF) bus.spi_clk = 1'b0;
      end
   endtask

   task automatic frame_start(input logic [7:0] op, input logic [23:0] addr);
      @(negedge clk);
      bus.spi_select = 1'b0;
      #(HALF);
      spi_bits(op, 8);
      if (op != 8'h9F) begin
         spi_bits(addr[23:16], 8);
         spi_bits(addr[15:8], 8);
         spi_bits(addr[7:0], 8);
      end
   endtask

   task automatic frame_end();
      cap_en = 1'b0;
      #(HALF) bus.spi_select = 1'b1;
      #(10 * HALF);
   endtask

   task automatic read_bytes(input logic [7:0] exp[], input string name);
      foreach (exp[i]) exp_spi.push_back('{$sformatf("%s_b%0d", name, i), 32'(exp[i])});
      cap_en = 1'b1;
      for (int i = 0; i < exp.size(); i++) spi_bits(8'h00, 8);
   endtask

   initial begin
      #(1_000_000);
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      bus.spi_clk     = 1'b0;
      bus.spi_mosi    = 1'b0;
      bus.spi_select  = 1'b1;
      bus.debug_addr  = '0;
      bus.debug_we    = 1'b0;
      bus.debug_wdata = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      check("reset_miso", 32'(bus.spi_miso), 32'd0);
      check("reset_error", 32'(bus.error), 32'd0);
      dbg_read(14'd0, 32'h0000_0000, "dbg_word0_empty");

      dbg_write(14'd1, 32'hDDCC_BBAA);
      dbg_read(14'd1, 32'hDDCC_BBAA, "dbg_word1_preload");

      frame_start(8'h03, 24'h000004);
      read_bytes('{8'hAA, 8'hBB, 8'hCC, 8'hDD}, "read03");
      frame_end();

      frame_start(8'h02, 24'h000010);
      spi_bits(8'h11, 8);
      spi_bits(8'h22, 8);
      spi_bits(8'h33, 8);
      spi_bits(8'hF8, 5);
      frame_end();
      dbg_read(14'd4, 32'h0033_2211, "write02_word4");

      frame_start(8'h0B, 24'h000004);
      read_bytes('{8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD}, "fast0B");
      frame_end();

      dbg_write(14'h3FFF, 32'h5A00_0000);
      dbg_write(14'd0, 32'h0000_00C3);
      frame_start(8'h03, 24'h00FFFF);
      read_bytes('{8'h5A, 8'hC3}, "wrap");
      frame_end();

      frame_start(8'h9F, 24'h000000);
      read_bytes('{8'h00, 8'h00}, "ignore9F");
      frame_end();
      check("error_after_9F", 32'(bus.error), 32'd1);
      frame_start(8'h03, 24'h000004);
      read_bytes('{8'hAA, 8'hBB}, "read_after_err");
      frame_end();
      check("error_sticky", 32'(bus.error), 32'd1);

      frame_start(8'h02, 24'h000020);
      spi_bits(8'hA0, 4);
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_midwrite_miso", 32'(bus.spi_miso), 32'd0);
      check("rst_clears_error", 32'(bus.error), 32'd0);
      frame_end();
      dbg_read(14'd8, 32'h0000_0000, "rst_midwrite_word8");
      frame_start(8'h03, 24'h000004);
      read_bytes('{8'hAA}, "read_after_rst");
      frame_end();

      repeat (4) @(negedge clk);
      check("spi_queue_drained", 32'(exp_spi.size()), 32'd0);
      check("dbg_queue_drained", 32'(exp_dbg.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
